// File: rtl/pairing_result_uart_tx_if.sv
// Bus bundle between the pairing core read port, the readout engine and the
// host-side controls. The slave modport is the readout engine; the master
// modport is whatever drives it (controller plus the core's read data).
`timescale 1ns/1ps

interface pairing_result_uart_tx_if #(
  parameter int DATA_W = 304,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] extout_addr;
  logic [DATA_W-1:0] extout_data;
  logic              uart_txd;
  logic              busy;
  logic              done;

  modport master (
    output start, first_addr, word_count, extout_data,
    input  extout_addr, uart_txd, busy, done
  );

  modport slave (
    input  start, first_addr, word_count, extout_data,
    output extout_addr, uart_txd, busy, done
  );
endinterface

// File: rtl/pairing_result_uart_tx.sv
// Result-readout engine: walks a range of extout_addr words, captures each
// word once, and sends it MSB-byte first as 8N1 UART frames on uart_txd.
// All outputs are registered; their next values are decoded from the
// next-state logic so the serial line never glitches.
`timescale 1ns/1ps

module pairing_result_uart_tx #(
  parameter int DATA_W       = 304,
  parameter int ADDR_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int RD_LAT       = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  pairing_result_uart_tx_if.slave   bus
);

  localparam int NB      = (DATA_W + 7) / 8;
  localparam int SH_W    = NB * 8;
  localparam int CNT_MAX = (CLKS_PER_BIT > RD_LAT) ? CLKS_PER_BIT : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BYTE_W  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START_BIT, S_DATA_BITS, S_STOP_BIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // baud / read-latency counter
  logic [2:0]        bit_q, bit_d;     // data bit index within a frame
  logic [BYTE_W-1:0] byte_q, byte_d;   // bytes left in the word after this one
  logic [ADDR_W-1:0] word_q, word_d;   // words left including the current one
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        top_byte;
  logic              tick;
  logic              fetch_end;

  assign tick      = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign fetch_end = (cnt_q == CNT_W'(RD_LAT - 1));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    word_d   = word_q;
    addr_d   = addr_q;
    shreg_d  = shreg_q;
    top_byte = 8'h00;
    txd_d    = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.first_addr;
          word_d  = bus.word_count;
          cnt_d   = '0;
          state_d = (bus.word_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_end) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        shreg_d = SH_W'(bus.extout_data);
        byte_d  = BYTE_W'(NB - 1);
        cnt_d   = '0;
        state_d = S_START_BIT;
      end
      S_START_BIT: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA_BITS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA_BITS: begin
        if (tick) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP_BIT;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP_BIT: begin
        if (tick) begin
          cnt_d = '0;
          if (byte_q != '0) begin
            shreg_d = shreg_q << 8;
            byte_d  = byte_q - BYTE_W'(1);
            state_d = S_START_BIT;
          end else if (word_q > ADDR_W'(1)) begin
            addr_d  = addr_q + ADDR_W'(1);
            word_d  = word_q - ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level for the coming cycle, taken from the coming state.
    top_byte = shreg_d[SH_W-1 -: 8];
    if (state_d == S_START_BIT)      txd_d = 1'b0;
    else if (state_d == S_DATA_BITS) txd_d = top_byte[bit_d];

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers; async reset forces the line idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the shift register is reset along with control so the whole
      // block has one defined reset state; it holds no array, so this is free.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.extout_addr = addr_q;
  assign bus.uart_txd    = txd_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: doc/pairing_result_uart_tx.md
# pairing_result_uart_tx

Parametrised result-readout engine for the pairing core. On `start` it walks a range of `extout_addr` words, captures each `DATA_W`-bit word, splits it into bytes (most-significant byte first), and transmits every byte as a standard 8N1 UART frame on `uart_txd`. It replaces the single-bit shift-register debug readout with a host-parsable serial stream, sits between `BN254_pairing`'s external read port and the board UART pin, and runs entirely on the core clock.

## Interface
Parameters:
- `DATA_W`, 304, width of one `extout_data` word
- `ADDR_W`, 8, width of `extout_addr`
- `CLKS_PER_BIT`, 868, core clocks per UART bit (≥2)
- `RD_LAT`, 1, cycles from `extout_addr` change to valid `extout_data` (≥1)
- Derived: `NB = ceil(DATA_W/8)` bytes per word; word zero-extended on the MSB side to `NB*8` bits

Ports:
- `clk` in 1: core clock
- `rstn` in 1: reset. One clock; reset is asynchronous and active-low.
- `start` in 1: single-cycle request, sampled only in IDLE
- `first_addr` in ADDR_W: first word address, captured on accepted `start`
- `word_count` in ADDR_W: number of words to send, captured on accepted `start`
- `extout_addr` out ADDR_W: registered read address to the core
- `extout_data` in DATA_W: read data from the core
- `uart_txd` out 1: serial output, idle high
- `busy` out 1: high from the cycle after accepted `start` until `done`
- `done` out 1: one-cycle pulse when the whole transfer ends

## Operation
- States: IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, DONE.
- IDLE: `start`=1 → latch `first_addr` into `extout_addr`, `word_count` into the remaining-word counter. If `word_count`=0 → DONE; otherwise → FETCH.
- FETCH: wait `RD_LAT` cycles with `extout_addr` held stable → LOAD.
- LOAD: capture `extout_data` into a `NB*8`-bit shift register; byte counter=`NB`-1 → START_BIT.
- START_BIT: `uart_txd`=0 for `CLKS_PER_BIT` cycles → DATA_BITS.
- DATA_BITS: send current top byte LSB first, one bit per `CLKS_PER_BIT` cycles, 8 bits → STOP_BIT.
- STOP_BIT: `uart_txd`=1 for `CLKS_PER_BIT` cycles, then:
  - bytes remain: shift register left 8, decrement byte counter → START_BIT.
  - last byte, words remain: `extout_addr`+1 (mod 2^ADDR_W), decrement word counter → FETCH.
  - last byte of last word → DONE.
- DONE: `done`=1 for one cycle, `busy`=0 in the same cycle → IDLE.
- `start` outside IDLE: ignored, no effect on the transfer in progress.
- `extout_data` changing outside LOAD: no effect; each word is sampled exactly once.
- `uart_txd` is driven high in IDLE, FETCH, LOAD, DONE and STOP_BIT.
- Address wrap: `first_addr`=2^ADDR_W-1 with `word_count`≥2 continues at address 0.

## Timing
- Reset values (asynchronous, immediate on `rstn`=0): `uart_txd`=1, `busy`=0, `done`=0, `extout_addr`=0, state IDLE, all counters 0.
- Reset asserted mid-frame: `uart_txd` returns high in the same instant. No partial-frame completion. After release, the block idles until a new `start`.
- `start` accepted at edge T: `extout_addr`=`first_addr` and `busy`=1 from T+1. LOAD at T+1+`RD_LAT`. Start bit begins at T+2+`RD_LAT`.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles. Consecutive bytes of one word follow with zero gap.
- Inter-word gap: `RD_LAT`+1 idle-high cycles between the stop bit of one word and the start bit of the next.
- Total for N>0 words: N·(`RD_LAT`+1+`NB`·10·`CLKS_PER_BIT`) cycles from T+1 to the DONE cycle inclusive, minus one cycle.
- `word_count`=0: `done` pulses at T+1, `busy` is never asserted, `uart_txd` stays high.
- Bit counter counts 0..`CLKS_PER_BIT`-1. No fractional-baud correction.

## Test plan
Bench parameters: `DATA_W`=12, `CLKS_PER_BIT`=4, `RD_LAT`=1, so `NB`=2.
- Single word: memory[5]=0xABC, `start` with `first_addr`=5, `word_count`=1 → byte 0x0A then 0xBC. Each frame is 0 + LSB-first data + 1, 4 cycles per bit. `done` pulse once, 82 cycles after `busy` rises.
- Multi-word wrap: `first_addr`=255, `word_count`=2, memory[255]=0x123, memory[0]=0xFFF → `extout_addr` sequence 255, 0; bytes 0x01, 0x23, 0x0F, 0xFF; 2-cycle high gap between words.
- Zero count: `word_count`=0 → `done` at T+1, `busy` never high, `uart_txd` constant 1.
- Start while busy: pulse `start` with a different `first_addr` during the second byte → stream and `extout_addr` unchanged, single `done`.
- Async reset mid-data-bit: drop `rstn` between clock edges while `uart_txd`=0 → `uart_txd`=1, `busy`=0, `extout_addr`=0 immediately. After release and a fresh `start`, a clean frame is sent.
- Data stability: toggle `extout_data` every cycle outside LOAD → transmitted bytes equal the value present in the LOAD cycle only.
